mul_seq_ctrl: RTL
=================

# mul_seq_ctrl

Sequencer for a multi-cycle int8 sign-magnitude multiplier built around one shared `mult4x4` nibble multiplier. It accepts one 8x8 operand pair per transaction over a valid/ready handshake and issues the four nibble partial products through the single `mult4x4` instance over four cycles. It accumulates the shifted partial products and returns a 16-bit signed result with a sideband tag. It sits in the CMAC approximate reduced-int8 path as the area-reduced alternative to the fully parallel four-instance multiplier.

## Interface
- `TAG_W`, 4: width of the pass-through transaction tag.
- `nvdla_core_clk` in 1: core clock; all state on rising edge.
- `nvdla_core_rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block can accept an operand pair.
- `in_a` in 8: signed int8 operand A.
- `in_b` in 8: signed int8 operand B.
- `in_tag` in TAG_W: tag, returned unchanged with the result.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out 16: signed product.
- `out_tag` out TAG_W: tag of the current result.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, PP1, PP2, PP3, PP4, DONE.
- In IDLE, `in_valid & in_ready` captures the operands:
  - sign = `a[7]^b[7]`.
  - |a| and |b| are registered as 8-bit magnitudes.
  - `in_tag` is registered.
  - The accumulator clears to 0 and the FSM moves to PP1.
- Magnitude rule: one's complement, so a negative x gives `~x`.
- One `mult4x4` instance. Its operand muxes are driven by the state:
  - PP1: a_lo × b_lo, added at shift 0.
  - PP2: a_hi × b_lo, added at shift 4.
  - PP3: a_lo × b_hi, added at shift 4.
  - PP4: a_hi × b_hi, added at shift 8.
- Accumulator is 16 bits, unsigned. Each addition wraps modulo 2^16.
- The partial-product order is fixed as listed above.
- After PP4 the FSM enters DONE.
  - `out_data` = sign ? `~acc` : `acc`, registered when entering DONE.
  - `out_valid` = 1 while in DONE.
- In DONE, `out_valid & out_ready` retires the result:
  - If `in_valid` is also high in that cycle, the new pair is captured and the next state is PP1.
  - Otherwise the next state is IDLE.
- `in_ready` = (state==IDLE) | (state==DONE & out_ready).
  - This is a combinational path from `out_ready` to `in_ready`.
- While `out_valid` is high and `out_ready` is low, `out_data` and `out_tag` hold stable and nothing new is accepted.
- `in_*` inputs are ignored outside the accept cycle.
- The result is bit-identical to the parallel reduced-int8 multiplier built with the same `mult4x4` variant.

## Timing
- Reset values:
  - state = IDLE.
  - `out_valid` = 0, `out_data` = 0, `out_tag` = 0.
  - `busy` = 0.
  - `in_ready` = 1, because it derives from IDLE.
  - Accumulator and operand registers = 0.
- Latency: accept at cycle N, PP1..PP4 at cycles N+1..N+4, `out_valid` high at cycle N+5.
- Throughput with `out_ready` held high: one result every 5 cycles.
- Reset asserted mid-transaction aborts it immediately. No result is emitted, and the block is ready in the first cycle after deassertion.

## Configuration
- `MUL_SEQ_EXACT_2C_EN`
  - Defined: magnitudes use two's complement (`-x`, so -128 gives 128 in 8 bits) and the result uses `-acc`. The output is the exact signed product when `mult4x4` is exact.
  - Undefined (default): one's complement on both the magnitudes and the result, i.e. the approximate path.
  - Latency and handshake are identical in both builds.

## Test plan
All expected values assume an exact `mult4x4`. A reference model using the bench's `mult4x4` variant checks all other cases.
- Reset check: assert reset -> `in_ready`=1, `out_valid`=0, `out_data`=0x0000, `busy`=0.
- Basic product: a=3, b=5, tag=0xA, accepted at cycle N -> `out_valid` at N+5, `out_data`=0x000F, `out_tag`=0xA.
- Sign cases:
  - a=0xFF, b=0x02 -> default build 0xFFFF; with `MUL_SEQ_EXACT_2C_EN` 0xFFFE.
  - a=0x80, b=0x80 -> default 0x3F01; with `MUL_SEQ_EXACT_2C_EN` 0x4000.
  - a=0x10, b=0x10 -> 0x0100 in both builds.
- Backpressure: hold `out_ready`=0 for 3 cycles after `out_valid` -> `out_data` and `out_tag` stable, `in_ready`=0 throughout, then exactly one retire.
- Back-to-back: `in_valid` and `out_ready` held high for 3 pairs -> results spaced 5 cycles apart, in order, with the new pair accepted in the retire cycle.
- Mid-transaction reset: assert reset in PP3 -> no `out_valid`, and the next transaction after reset completes correctly.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequencer for a multi-cycle int8 sign-magnitude multiplier.
// One operand pair is accepted per transaction over valid/ready. A single shared
// 4x4 nibble multiplier is time-multiplexed over four partial-product cycles.
// The shifted partial products are accumulated, and a signed 16-bit result is
// returned together with the transaction tag.
//
// Build option: define MUL_SEQ_EXACT_2C_EN to use two's-complement magnitudes and
// result negation, which gives the exact signed product. Without it (the default),
// one's complement is used on both, which is the approximate reduced-int8 path.
module mul_seq_ctrl #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned OP_W  = 8;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned PP_W  = 2 * NIB_W;
  localparam int unsigned ACC_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PP1  = 3'd1,
    PP2  = 3'd2,
    PP3  = 3'd3,
    PP4  = 3'd4,
    DONE = 3'd5
  } state_e;

  state_e             state_q;
  logic [OP_W-1:0]    a_mag_q;
  logic [OP_W-1:0]    b_mag_q;
  logic               sign_q;
  logic [TAG_W-1:0]   tag_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   out_data_q;
  logic [TAG_W-1:0]   out_tag_q;
  logic               out_valid_q;
  logic               busy_q;

  logic               accept;
  logic [OP_W-1:0]    a_mag_d;
  logic [OP_W-1:0]    b_mag_d;
  logic [NIB_W-1:0]   mul_a;
  logic [NIB_W-1:0]   mul_b;
  logic [PP_W-1:0]    pp;
  logic [ACC_W-1:0]   pp_shifted;
  logic [ACC_W-1:0]   acc_d;
  logic [ACC_W-1:0]   result_d;

  // Operand magnitude: one's complement by default, two's complement in exact build
  function automatic logic [OP_W-1:0] magnitude(input logic [OP_W-1:0] x);
`ifdef MUL_SEQ_EXACT_2C_EN
    magnitude = x[OP_W-1] ? -x : x;
`else
    magnitude = x[OP_W-1] ? ~x : x;
`endif
  endfunction

  // Re-apply the sign to the unsigned accumulated magnitude
  function automatic logic [ACC_W-1:0] apply_sign(input logic s, input logic [ACC_W-1:0] m);
`ifdef MUL_SEQ_EXACT_2C_EN
    apply_sign = s ? -m : m;
`else
    apply_sign = s ? ~m : m;
`endif
  endfunction

  // Ready when idle, or when the held result retires in this same cycle
  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  assign a_mag_d  = magnitude(in_a);
  assign b_mag_d  = magnitude(in_b);

  // Operand muxes and partial-product alignment for the shared nibble multiplier
  always_comb begin
    mul_a      = a_mag_q[NIB_W-1:0];
    mul_b      = b_mag_q[NIB_W-1:0];
    pp_shifted = '0;
    unique case (state_q)
      PP1: begin
        mul_a      = a_mag_q[NIB_W-1:0];
        mul_b      = b_mag_q[NIB_W-1:0];
        pp_shifted = {8'd0, pp};
      end
      PP2: begin
        mul_a      = a_mag_q[OP_W-1:NIB_W];
        mul_b      = b_mag_q[NIB_W-1:0];
        pp_shifted = {4'd0, pp, 4'd0};
      end
      PP3: begin
        mul_a      = a_mag_q[NIB_W-1:0];
        mul_b      = b_mag_q[OP_W-1:NIB_W];
        pp_shifted = {4'd0, pp, 4'd0};
      end
      PP4: begin
        mul_a      = a_mag_q[OP_W-1:NIB_W];
        mul_b      = b_mag_q[OP_W-1:NIB_W];
        pp_shifted = {pp, 8'd0};
      end
      default: begin
        pp_shifted = '0;
      end
    endcase
  end

  // Shared mult4x4 nibble multiplier (exact variant)
  assign pp = PP_W'(mul_a) * PP_W'(mul_b);

  // Accumulate modulo 2^16 and form the signed result for the DONE transition
  assign acc_d    = acc_q + pp_shifted;
  assign result_d = apply_sign(sign_q, acc_d);

  // Operand capture and accumulation datapath
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      a_mag_q <= '0;
      b_mag_q <= '0;
      sign_q  <= 1'b0;
      tag_q   <= '0;
      acc_q   <= '0;
    end else if (accept) begin
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      sign_q  <= in_a[OP_W-1] ^ in_b[OP_W-1];
      tag_q   <= in_tag;
      acc_q   <= '0;
    end else if ((state_q == PP1) || (state_q == PP2) ||
                 (state_q == PP3) || (state_q == PP4)) begin
      acc_q   <= acc_d;
    end
  end

  // Control FSM with registered result, valid and busy outputs
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= PP1;
            busy_q  <= 1'b1;
          end
        end
        PP1: state_q <= PP2;
        PP2: state_q <= PP3;
        PP3: state_q <= PP4;
        PP4: begin
          state_q     <= DONE;
          out_data_q  <= result_d;
          out_tag_q   <= tag_q;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              state_q <= PP1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule
